clk_duty_monitor: RTL and testbench
===================================

Name: clk_duty_monitor

Overview:
- Downstream consumer of the team's generated test clock (10 MHz, 30% duty). Treats the generated clock as a data input `sig_in`.
- Oversamples `sig_in` with the system clock through a synchronizer and measures, per cycle of `sig_in`:
  - the period, in `clk` cycles;
  - the high time, in `clk` cycles;
  - a running count of rising edges.
- Optionally flags period/duty violations against expected values.
- Used in the clocking testbench and in on-chip clock health checking.

Parameters:
- CNT_W, 16: width of the period and high-time counters/outputs.
- SYNC_STAGES, 2: flip-flop stages in the `sig_in` synchronizer (legal values 2..4).
- EXP_PERIOD, 10: expected period in `clk` cycles (used only with DUTY_CHECK_EN).
- EXP_HIGH, 3: expected high time in `clk` cycles (used only with DUTY_CHECK_EN).
- TOL, 1: allowed absolute deviation, in `clk` cycles, for period and high time.

Ports:
- clk  input  1  system sampling clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  monitored clock; asynchronous to `clk`.
- enable  input  1  measurement enable; when low, the FSM is held in WAIT_RISE.
- clear  input  1  synchronous clear of `edge_count`, `timeout` and the error flags.
- period_cnt  output  CNT_W  last measured period.
- high_cnt  output  CNT_W  last measured high time.
- meas_valid  output  1  one-cycle pulse when `period_cnt`/`high_cnt` update.
- edge_count  output  32  detected rising edges of `sig_in`.
- timeout  output  1  sticky; a counter saturated (stuck or too-slow input).
- err_period  output  1  sticky; period out of tolerance (feature only).
- err_duty  output  1  sticky; high time out of tolerance (feature only).

Behaviour:
- Reset (`rst_n` low, async):
  - All outputs are 0; the FSM is in WAIT_RISE; counters and synchronizer flops are 0.
  - Reset asserted mid-measurement discards the partial measurement; the first valid result after release needs two fresh rises.
- Synchronizer and edge detect:
  - `s` is the last synchronizer stage; `s_d` is `s` delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Input-to-detect latency is SYNC_STAGES+1 `clk` cycles.
- edge_count:
  - Increments by 1 on every rise while `enable` is high, in any FSM state.
  - Wraps 0xFFFFFFFF -> 0.
- FSM states: WAIT_RISE, MEAS_HIGH, MEAS_LOW.
- WAIT_RISE:
  - On a rise with `enable`: go to MEAS_HIGH, set pcnt=1, hcnt=1.
  - No `meas_valid` is produced (first edge only arms the measurement).
- MEAS_HIGH:
  - Each cycle without a fall: pcnt++, hcnt++.
  - On a fall: go to MEAS_LOW, pcnt++, hcnt frozen.
- MEAS_LOW:
  - Each cycle without a rise: pcnt++.
  - On a rise:
    - `period_cnt` <= pcnt and `high_cnt` <= hcnt, registered.
    - `meas_valid`=1 for exactly that next cycle.
    - Go to MEAS_HIGH with pcnt=1, hcnt=1.
- Measured values: a `sig_in` with period P cycles and high time H cycles (both ≥ 2) yields `period_cnt`=P and `high_cnt`=H.
- Saturation: if pcnt reaches 2^CNT_W-1 in MEAS_HIGH or MEAS_LOW:
  - Set `timeout`=1 and go to WAIT_RISE.
  - No `meas_valid` is produced.
- `enable` low: forces WAIT_RISE next cycle; `period_cnt`/`high_cnt` hold their last values.
- `clear`:
  - Zeroes `edge_count`, `timeout`, `err_period` and `err_duty` next cycle.
  - Does not affect the FSM or the measurement registers.
  - If `clear` and a rise coincide, `clear` wins: `edge_count`=0, not 1.
- Glitches: pulses shorter than one `clk` period may be missed; they are not required to be detected.

Optional Feature:
- Macro: DUTY_CHECK_EN.
- When defined, in the cycle `meas_valid` is asserted:
  - `err_period` sets if |period_cnt−EXP_PERIOD| > TOL;
  - `err_duty` sets if |high_cnt−EXP_HIGH| > TOL.
  - Comparisons are unsigned, using CNT_W+1-bit differences.
  - Both flags are sticky until `clear` or reset.
- When not defined: `err_period` and `err_duty` are tied to 0 and no comparator logic is generated.

Test Plan:
- Basic measurement:
  - Stimulus: `enable`=1; `sig_in` high 3 / low 7 `clk` cycles, 5 periods.
  - Response: first `meas_valid` after the 2nd rise; then one pulse per period with `period_cnt`=10, `high_cnt`=3; `edge_count`=5.
- Tolerance check (DUTY_CHECK_EN, EXP 10/3, TOL 1):
  - Stimulus: period 11 with high 4.
  - Response: no errors.
  - Stimulus: then period 12 with high 3.
  - Response: `err_period`=1, `err_duty`=0.
  - Stimulus: pulse `clear`.
  - Response: both flags 0.
- Stuck input (CNT_W=8):
  - Stimulus: after one rise, hold `sig_in` high.
  - Response: `timeout`=1 once pcnt hits 255; FSM in WAIT_RISE; no `meas_valid`.
  - Stimulus: resume a 10/3 clock.
  - Response: valid 10/3 results resume after two rises.
- Reset mid-operation:
  - Stimulus: assert `rst_n` low during MEAS_LOW.
  - Response: all outputs 0 immediately (async); after release, `meas_valid` only after two rises.
- Enable and clear:
  - Stimulus: drop `enable` for 20 cycles.
  - Response: `edge_count` frozen; `period_cnt` holds 10.
  - Stimulus: `clear` coincident with a detected rise.
  - Response: `edge_count`=0.

Source files
------------

// File: rtl/clk_duty_monitor.sv
// Measures period and high time of an asynchronous clock, oversampled by clk.
// Optional tolerance checking against expected values under DUTY_CHECK_EN.
module clk_duty_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_PERIOD  = 10,
  parameter int EXP_HIGH    = 3,
  parameter int TOL         = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic [31:0]      edge_count,
  output logic             timeout,
  output logic             err_period,
  output logic             err_duty
);

  typedef enum logic [1:0] {
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d;
  logic                   rise, fall;
  logic [CNT_W-1:0]       pcnt, hcnt;
  logic [CNT_W-1:0]       pcnt_nxt, hcnt_nxt;
  logic                   done, sat, sat_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign sat  = (state != WAIT_RISE) && (pcnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_RISE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = WAIT_RISE;
    end else begin
      unique case (state)
        WAIT_RISE: if (rise) state_nxt = MEAS_HIGH;
        MEAS_HIGH: begin
          if (sat)       state_nxt = WAIT_RISE;
          else if (fall) state_nxt = MEAS_LOW;
        end
        MEAS_LOW: begin
          if (sat)       state_nxt = WAIT_RISE;
          else if (rise) state_nxt = MEAS_HIGH;
        end
        default: state_nxt = WAIT_RISE;
      endcase
    end
  end

  // Saturation takes priority so a stuck input never yields a result.
  always_comb begin
    pcnt_nxt = pcnt;
    hcnt_nxt = hcnt;
    done     = 1'b0;
    sat_hit  = 1'b0;
    if (enable) begin
      unique case (state)
        WAIT_RISE: begin
          if (rise) begin
            pcnt_nxt = CNT_ONE;
            hcnt_nxt = CNT_ONE;
          end
        end
        MEAS_HIGH: begin
          if (sat) begin
            sat_hit = 1'b1;
          end else if (fall) begin
            pcnt_nxt = pcnt + CNT_ONE;
          end else begin
            pcnt_nxt = pcnt + CNT_ONE;
            hcnt_nxt = hcnt + CNT_ONE;
          end
        end
        MEAS_LOW: begin
          if (sat) begin
            sat_hit = 1'b1;
          end else if (rise) begin
            done     = 1'b1;
            pcnt_nxt = CNT_ONE;
            hcnt_nxt = CNT_ONE;
          end else begin
            pcnt_nxt = pcnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      hcnt       <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
    end else begin
      pcnt       <= pcnt_nxt;
      hcnt       <= hcnt_nxt;
      meas_valid <= done;
      if (done) begin
        period_cnt <= pcnt;
        high_cnt   <= hcnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count <= '0;
      timeout    <= 1'b0;
    end else if (clear) begin
      edge_count <= '0;
      timeout    <= 1'b0;
    end else begin
      if (rise && enable) edge_count <= edge_count + 32'd1;
      if (sat_hit)        timeout    <= 1'b1;
    end
  end

`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W:0] EXP_P = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0] EXP_H = (CNT_W+1)'(EXP_HIGH);
  localparam logic [CNT_W:0] TOL_V = (CNT_W+1)'(TOL);

  logic [CNT_W:0] p_ext, h_ext;
  logic [CNT_W:0] p_diff, h_diff;

  assign p_ext = {1'b0, period_cnt};
  assign h_ext = {1'b0, high_cnt};

  always_comb begin
    p_diff = (p_ext >= EXP_P) ? p_ext - EXP_P : EXP_P - p_ext;
    h_diff = (h_ext >= EXP_H) ? h_ext - EXP_H : EXP_H - h_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_period <= 1'b0;
      err_duty   <= 1'b0;
    end else if (clear) begin
      err_period <= 1'b0;
      err_duty   <= 1'b0;
    end else if (meas_valid) begin
      if (p_diff > TOL_V) err_period <= 1'b1;
      if (h_diff > TOL_V) err_duty   <= 1'b1;
    end
  end
`else
  assign err_period = 1'b0;
  assign err_duty   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_duty_monitor.sv
// Directed bench for clk_duty_monitor (CNT_W=8); expectations adapt
// to whether DUTY_CHECK_EN is defined.
module tb_clk_duty_monitor;

  localparam int CNT_W = 8;

`ifdef DUTY_CHECK_EN
  localparam logic [31:0] EXP_ERRP = 32'd1;
`else
  localparam logic [31:0] EXP_ERRP = 32'd0;
`endif

  logic             clk;
  logic             rst_n;
  logic             sig_in;
  logic             enable;
  logic             clear;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_valid;
  logic [31:0]      edge_count;
  logic             timeout;
  logic             err_period;
  logic             err_duty;

  int n_chk;
  int n_pass;
  int n_meas;
  int snap;

  clk_duty_monitor #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .EXP_PERIOD  (10),
    .EXP_HIGH    (3),
    .TOL         (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .enable     (enable),
    .clear      (clear),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .edge_count (edge_count),
    .timeout    (timeout),
    .err_period (err_period),
    .err_duty   (err_duty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          n_meas = 0;
    else if (meas_valid) n_meas = n_meas + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic run_period(input int h, input int l);
    sig_in = 1'b1;
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    enable = 1'b1;
    clear  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", 32'(period_cnt), 32'd0);
    chk("rst_high", 32'(high_cnt), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_edges", edge_count, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_errp", 32'(err_period), 32'd0);
    chk("rst_errd", 32'(err_duty), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic 10/3 measurement
    run_period(3, 7);
    chk("first_rise_no_valid", 32'(n_meas), 32'd0);
    repeat (4) run_period(3, 7);
    chk("basic_nmeas", 32'(n_meas), 32'd4);
    chk("basic_period", 32'(period_cnt), 32'd10);
    chk("basic_high", 32'(high_cnt), 32'd3);
    chk("basic_edges", edge_count, 32'd5);
    chk("basic_timeout", 32'(timeout), 32'd0);
    chk("basic_errp", 32'(err_period), 32'd0);
    chk("basic_errd", 32'(err_duty), 32'd0);

    // enable low freezes everything
    enable = 1'b0;
    repeat (2) run_period(3, 7);
    chk("dis_edges", edge_count, 32'd5);
    chk("dis_period", 32'(period_cnt), 32'd10);
    chk("dis_nmeas", 32'(n_meas), 32'd4);
    enable = 1'b1;

    // clear coincident with a detected rise
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_rise_edges", edge_count, 32'd0);
    sig_in = 1'b0;
    repeat (7) @(negedge clk);
    chk("clr_rise_hold", edge_count, 32'd0);

    // tolerance: 11/4 in range, then 12/3 out on period
    run_period(4, 7);
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    sig_in = 1'b0;
    @(negedge clk);
    chk("tol11_period", 32'(period_cnt), 32'd11);
    chk("tol11_high", 32'(high_cnt), 32'd4);
    chk("tol11_errp", 32'(err_period), 32'd0);
    chk("tol11_errd", 32'(err_duty), 32'd0);
    repeat (8) @(negedge clk);
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("tol12_period", 32'(period_cnt), 32'd12);
    chk("tol12_high", 32'(high_cnt), 32'd3);
    chk("tol12_errp", 32'(err_period), EXP_ERRP);
    chk("tol12_errd", 32'(err_duty), 32'd0);
    chk("tol_edges", edge_count, 32'd3);
    pulse_clear();
    chk("clr_errp", 32'(err_period), 32'd0);
    chk("clr_errd", 32'(err_duty), 32'd0);
    chk("clr_edges", edge_count, 32'd0);

    // stuck low, then stuck high after one rise
    repeat (300) @(negedge clk);
    chk("stuck_low_timeout", 32'(timeout), 32'd1);
    pulse_clear();
    chk("clr_timeout", 32'(timeout), 32'd0);
    snap = n_meas;
    sig_in = 1'b1;
    repeat (300) @(negedge clk);
    chk("stuck_high_timeout", 32'(timeout), 32'd1);
    chk("stuck_high_nmeas", 32'(n_meas), 32'(snap));
    chk("stuck_high_edges", edge_count, 32'd1);
    sig_in = 1'b0;
    repeat (5) @(negedge clk);
    snap = n_meas;
    run_period(3, 7);
    chk("resume_armed_only", 32'(n_meas), 32'(snap));
    repeat (2) run_period(3, 7);
    chk("resume_nmeas", 32'(n_meas - snap), 32'd2);
    chk("resume_period", 32'(period_cnt), 32'd10);
    chk("resume_high", 32'(high_cnt), 32'd3);

    // async reset during MEAS_LOW
    rst_n = 1'b0;
    #1;
    chk("arst_period", 32'(period_cnt), 32'd0);
    chk("arst_high", 32'(high_cnt), 32'd0);
    chk("arst_edges", edge_count, 32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    chk("arst_valid", 32'(meas_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_period(3, 7);
    chk("post_rst_one_rise", 32'(n_meas), 32'd0);
    chk("post_rst_period0", 32'(period_cnt), 32'd0);
    run_period(3, 7);
    chk("post_rst_nmeas", 32'(n_meas), 32'd1);
    chk("post_rst_period", 32'(period_cnt), 32'd10);
    chk("post_rst_high", 32'(high_cnt), 32'd3);
    chk("post_rst_edges", edge_count, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
